// File: rtl/ion_current_engine.sv
// ion_current_engine: I = g_max * a^GATE_EXP * b^HAS_INACT * (V - E_rev)
// Signed fixed point, one shared multiplier stepped by a small FSM.
module ion_current_engine #(
  parameter int W         = 16,
  parameter int FRAC      = 8,
  parameter int GATE_EXP  = 4,
  parameter int HAS_INACT = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] V,
  input  logic signed [W-1:0] e_rev,
  input  logic signed [W-1:0] g_max,
  input  logic signed [W-1:0] gate_a,
  input  logic signed [W-1:0] gate_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] I_out,
  output logic                out_sat
);

  if (GATE_EXP < 1 || GATE_EXP > 4) begin : g_bad_exp
    $error("ion_current_engine: GATE_EXP must be 1..4");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_DIFF, S_POW, S_INACT,
    S_GMAX, S_DRIVE, S_DONE
  } state_t;

  localparam int ONE_I = 2**FRAC;
  localparam logic signed [W-1:0] ONE =
    ONE_I[W-1:0];
  localparam logic signed [W-1:0] MAX_W =
    {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MIN_W =
    {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W:0] RND =
    {{(2*W){1'b0}}, 1'b1} << (FRAC-1);
  localparam logic [2:0] CNT_LAST =
    3'(GATE_EXP-2);
  localparam bit HAS_POW = (GATE_EXP > 1);
  localparam bit INACT_EN = (HAS_INACT != 0);

  state_t r_state, w_next;

  logic                r_in_ready;
  logic                r_out_valid;
  logic signed [W-1:0] r_I;
  logic                r_out_sat;
  logic                r_sat;
  logic [2:0]          r_cnt;
  logic signed [W-1:0] r_acc, r_diff;
  logic signed [W-1:0] r_v, r_e, r_g;
  logic signed [W-1:0] r_ga, r_gb;

  logic signed [W-1:0]   w_ma, w_mb;
  logic signed [2*W-1:0] w_prod;
  logic signed [2*W:0]   w_rnd, w_shr;
  logic                  w_mul_ovf;
  logic signed [W-1:0]   w_mres;
  logic signed [W:0]     w_d;
  logic                  w_d_ovf;
  logic signed [W-1:0]   w_dres;

  // Gates live in [0, 1.0]; out-of-range values are pinned, not flagged.
  function automatic logic signed [W-1:0] clamp_gate(
    input logic signed [W-1:0] g
  );
    if (g < 0)
      return '0;
    else if (g > ONE)
      return ONE;
    else
      return g;
  endfunction

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign I_out     = r_I;
  assign out_sat   = r_out_sat;

  // Select the multiplier's second operand from the current step.
  always_comb begin
    w_ma = r_acc;
    w_mb = r_diff;
    case (r_state)
      S_POW:   w_mb = r_ga;
      S_INACT: w_mb = r_gb;
      S_GMAX:  w_mb = r_g;
      default: w_mb = r_diff;
    endcase
  end

  // Shared multiply, round half up, saturate to W bits.
  always_comb begin
    w_prod = (2*W)'(w_ma) * (2*W)'(w_mb);
    w_rnd  = $signed({w_prod[2*W-1], w_prod}) + RND;
    w_shr  = w_rnd >>> FRAC;
    w_mul_ovf = !((&w_shr[2*W:W-1]) ||
                  !(|w_shr[2*W:W-1]));
    w_mres = w_shr[W-1:0];
    if (w_mul_ovf)
      w_mres = w_shr[2*W] ? MIN_W : MAX_W;
  end

  // Driving force V - E_rev at W+1 bits, saturated back to W.
  always_comb begin
    w_d = $signed({r_v[W-1], r_v}) -
          $signed({r_e[W-1], r_e});
    w_d_ovf = w_d[W] ^ w_d[W-1];
    w_dres  = w_d[W-1:0];
    if (w_d_ovf)
      w_dres = w_d[W] ? MIN_W : MAX_W;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // Next-state sequencing through the product chain.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (in_valid && r_in_ready)
          w_next = S_DIFF;
      S_DIFF:
        if (HAS_POW)
          w_next = S_POW;
        else if (INACT_EN)
          w_next = S_INACT;
        else
          w_next = S_GMAX;
      S_POW:
        if (r_cnt == CNT_LAST)
          w_next = INACT_EN ? S_INACT : S_GMAX;
      S_INACT: w_next = S_GMAX;
      S_GMAX:  w_next = S_DRIVE;
      S_DRIVE: w_next = S_DONE;
      S_DONE:
        if (out_ready)
          w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath, handshake and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_I         <= '0;
      r_out_sat   <= 1'b0;
      r_sat       <= 1'b0;
      r_cnt       <= '0;
      r_acc       <= '0;
      r_diff      <= '0;
      r_v         <= '0;
      r_e         <= '0;
      r_g         <= '0;
      r_ga        <= '0;
      r_gb        <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_sat      <= 1'b0;
            r_v        <= V;
            r_e        <= e_rev;
            r_g        <= g_max;
            r_ga       <= clamp_gate(gate_a);
            r_gb       <= clamp_gate(gate_b);
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        S_DIFF: begin
          r_diff <= w_dres;
          r_sat  <= r_sat | w_d_ovf;
          r_acc  <= r_ga;
          r_cnt  <= '0;
        end
        S_POW: begin
          r_acc <= w_mres;
          r_sat <= r_sat | w_mul_ovf;
          r_cnt <= r_cnt + 3'd1;
        end
        S_INACT, S_GMAX: begin
          r_acc <= w_mres;
          r_sat <= r_sat | w_mul_ovf;
        end
        S_DRIVE: begin
          r_I         <= w_mres;
          r_out_sat   <= r_sat | w_mul_ovf;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
